wb_stage_param: RTL

- Parameterised write-back stage; sits between the memory stage and the register file.
- Registers one instruction per cycle under a valid/ready handshake, and stalls when the shared register-file write port is not granted.
- Extracts, aligns and sign/zero-extends load data (byte/half/word/double), suppresses x0 writes and flags illegal load sizes.
- Exports forwarding, hazard, retire-count and trace signals.

---
 rtl/wb_stage_param.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/wb_stage_param.sv
// Write-back stage: holds one retiring instruction, extracts and extends load data,
// and arbitrates for the shared register-file write port.
module wb_stage_param #(
  parameter int XLEN  = 32,
  parameter int RF_AW = 5,
  parameter int CNT_W = 64,
  parameter int OFF_W = $clog2(XLEN/8)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [RF_AW-1:0] in_rd,
  input  logic             in_we,
  input  logic             in_is_load,
  input  logic [1:0]       in_ld_size,
  input  logic             in_ld_unsigned,
  input  logic [OFF_W-1:0] in_ld_off,
  input  logic [XLEN-1:0]  in_alu_result,
  input  logic [XLEN-1:0]  in_ld_word,
  input  logic             rf_grant,
  output logic             rf_we,
  output logic [RF_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic             fwd_valid,
  output logic [RF_AW-1:0] fwd_rd,
  output logic [XLEN-1:0]  fwd_data,
  output logic             ld_err,
  output logic [CNT_W-1:0] instret,
  output logic [XLEN-1:0]  dbg_pc,
  output logic             dbg_we,
  output logic [RF_AW-1:0] dbg_wnum,
  output logic [XLEN-1:0]  dbg_wdata
);

  logic             v;
  logic [XLEN-1:0]  pc_r;
  logic [RF_AW-1:0] rd_r;
  logic             we_r;
  logic             is_load_r;
  logic [1:0]       ld_size_r;
  logic             ld_unsigned_r;
  logic [OFF_W-1:0] ld_off_r;
  logic [XLEN-1:0]  alu_result_r;
  logic [XLEN-1:0]  ld_word_r;

  logic             wr_needed;
  logic             complete;
  logic             accept;
  logic             retire;

  logic [OFF_W-1:0] off_al;
  logic [OFF_W+2:0] shamt;
  logic [XLEN-1:0]  shifted;
  logic [XLEN-1:0]  keep;
  logic             sign_bit;
  logic [XLEN-1:0]  ld_ext;
  logic [XLEN-1:0]  wdata;

  assign wr_needed = we_r & (rd_r != '0);
  // Double-word loads only exist on a 64-bit datapath.
  assign ld_err    = v & is_load_r & (ld_size_r == 2'b11) & (XLEN == 32);
  assign complete  = v & (rf_grant | ld_err | !wr_needed);
  assign in_ready  = !v | complete;
  assign accept    = in_valid & in_ready & !flush;
  assign retire    = v & !flush & !ld_err & complete;

  // Misaligned low offset bits are dropped by rounding down to the access size.
  always_comb begin
    off_al   = ld_off_r;
    keep     = '1;
    sign_bit = 1'b0;
    case (ld_size_r)
      2'b00: off_al = ld_off_r;
      2'b01: off_al = ld_off_r & ~OFF_W'(1);
      2'b10: off_al = ld_off_r & ~OFF_W'(3);
      default: off_al = '0;
    endcase
    shamt   = {off_al, 3'b000};
    shifted = ld_word_r >> shamt;
    case (ld_size_r)
      2'b00: begin keep = XLEN'(8'hFF);         sign_bit = shifted[7];  end
      2'b01: begin keep = XLEN'(16'hFFFF);      sign_bit = shifted[15]; end
      2'b10: begin keep = XLEN'(32'hFFFF_FFFF); sign_bit = shifted[31]; end
      default: begin keep = '1;                 sign_bit = 1'b0;        end
    endcase
    ld_ext = (shifted & keep) | ({XLEN{sign_bit & !ld_unsigned_r}} & ~keep);
  end

  assign wdata     = is_load_r ? ld_ext : alu_result_r;

  assign rf_we     = v & wr_needed & !ld_err & !flush;
  assign rf_waddr  = rd_r;
  assign rf_wdata  = wdata;
  assign fwd_valid = v & wr_needed & !ld_err;
  assign fwd_rd    = rd_r;
  assign fwd_data  = wdata;
  assign dbg_pc    = pc_r;
  assign dbg_we    = rf_we;
  assign dbg_wnum  = rd_r;
  assign dbg_wdata = wdata;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; the latched fields are flip-flops, not a
  // memory, so clearing them on reset is cheap and keeps outputs at 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      v             <= 1'b0;
      pc_r          <= '0;
      rd_r          <= '0;
      we_r          <= 1'b0;
      is_load_r     <= 1'b0;
      ld_size_r     <= '0;
      ld_unsigned_r <= 1'b0;
      ld_off_r      <= '0;
      alu_result_r  <= '0;
      ld_word_r     <= '0;
      instret       <= '0;
    end else begin
      if (flush)         v <= 1'b0;
      else if (accept)   v <= 1'b1;
      else if (complete) v <= 1'b0;

      if (accept) begin
        pc_r          <= in_pc;
        rd_r          <= in_rd;
        we_r          <= in_we;
        is_load_r     <= in_is_load;
        ld_size_r     <= in_ld_size;
        ld_unsigned_r <= in_ld_unsigned;
        ld_off_r      <= in_ld_off;
        alu_result_r  <= in_alu_result;
        ld_word_r     <= in_ld_word;
      end

      if (retire) instret <= instret + CNT_W'(1);
    end
  end

endmodule
